// File: rtl/scarv_cop_entropy_src_if.sv
// ---------------------------------------------------------------------------
// scarv_cop_entropy_src_if
//   Valid/ready word channel between the entropy source (producer) and the
//   RNG seeding path (consumer).
//   es_valid : producer holds a word on es_data
//   es_ready : consumer accepts the word this cycle
//   es_data  : 32-bit entropy word (FIFO head)
// ---------------------------------------------------------------------------
interface scarv_cop_entropy_src_if;
  logic        es_valid;
  logic        es_ready;
  logic [31:0] es_data;

  modport master (output es_valid, output es_data, input  es_ready);
  modport slave  (input  es_valid, input  es_data, output es_ready);
endinterface

// File: rtl/scarv_cop_entropy_src.sv
// ---------------------------------------------------------------------------
// scarv_cop_entropy_src
//   Entropy source front-end: packs raw noise bits into 32-bit words (first
//   bit received = MSB), runs a repetition-count health test on the raw bits
//   and buffers healthy words in a small FIFO offered over valid/ready.
//
//   Optional build macro SCARV_COP_ES_VONNEUMANN_EN inserts a von Neumann
//   debiaser between the health test and the accumulator.
//
// Ports
//   g_clk, g_resetn : clock, async active-low reset
//   es_enable       : level, collect entropy while high
//   noise_valid     : noise_bit is valid this cycle
//   noise_bit       : raw noise bit
//   es_health_clr   : pulse, clears the sticky failure and leaves FAULT
//   es_health_fail  : sticky repetition-count failure flag
//   es_fill         : FIFO occupancy
//   es_if           : word channel (master side)
// ---------------------------------------------------------------------------
module scarv_cop_entropy_src #(
  parameter int FIFO_DEPTH = 4,
  parameter int RCT_CUTOFF = 16
) (
  input  logic                          g_clk,
  input  logic                          g_resetn,
  input  logic                          es_enable,
  input  logic                          noise_valid,
  input  logic                          noise_bit,
  input  logic                          es_health_clr,
  output logic                          es_health_fail,
  output logic [$clog2(FIFO_DEPTH):0]   es_fill,
  scarv_cop_entropy_src_if.master       es_if
);

  localparam int         AW      = $clog2(FIFO_DEPTH);
  localparam int         PW      = AW + 1;
  localparam logic [7:0] RCT_LIM = 8'(RCT_CUTOFF);

  typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_FAULT} state_e;

  state_e        state_q, state_d;
  logic [30:0]   acc_q, acc_d;          // 31 bits suffice: the 32nd completes the word
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    run_q, run_d;
  logic          last_bit_q, last_bit_d;
  logic          fail_q, fail_d;
  logic          word_pend_q, word_pend_d;  // completed word waiting for the FIFO write
  logic [31:0]   word_q, word_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]   mem_q [FIFO_DEPTH];

`ifdef SCARV_COP_ES_VONNEUMANN_EN
  logic          vn_phase_q, vn_phase_d;    // 1 = first bit of a pair held
  logic          vn_first_q, vn_first_d;
`endif

  logic          acc_bit_valid, acc_bit, rct_trip, word_done;
  logic [PW-1:0] fill;
  logic          full, pop, push;

  // --------------------------------------------------------------------------
  // Control, collection and health test
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d       = state_q;
    acc_d         = acc_q;
    bit_cnt_d     = bit_cnt_q;
    run_d         = run_q;
    last_bit_d    = last_bit_q;
    fail_d        = fail_q;
    word_d        = word_q;
    word_pend_d   = 1'b0;
    acc_bit_valid = 1'b0;
    acc_bit       = 1'b0;
    rct_trip      = 1'b0;
    word_done     = 1'b0;
`ifdef SCARV_COP_ES_VONNEUMANN_EN
    vn_phase_d    = vn_phase_q;
    vn_first_d    = vn_first_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
`ifdef SCARV_COP_ES_VONNEUMANN_EN
        vn_phase_d = 1'b0;
`endif
        if (es_enable) begin
          state_d   = ST_COLLECT;
          acc_d     = '0;
          bit_cnt_d = '0;
        end
      end

      ST_COLLECT: begin
        if (noise_valid) begin
          // Repetition count sees every raw bit, before any debiasing.
          last_bit_d = noise_bit;
          if (noise_bit == last_bit_q) run_d = (run_q == 8'hFF) ? run_q : run_q + 8'd1;
          else                         run_d = 8'd1;
          rct_trip = (run_d == RCT_LIM);
`ifdef SCARV_COP_ES_VONNEUMANN_EN
          vn_phase_d = ~vn_phase_q;
          if (!vn_phase_q) vn_first_d = noise_bit;
          // Pair (a,b) with a!=b yields a: 01 -> 0, 10 -> 1.
          acc_bit_valid = vn_phase_q && (vn_first_q != noise_bit);
          acc_bit       = vn_first_q;
`else
          acc_bit_valid = 1'b1;
          acc_bit       = noise_bit;
`endif
        end

        if (acc_bit_valid) begin
          acc_d     = {acc_q[29:0], acc_bit};
          bit_cnt_d = bit_cnt_q + 5'd1;
          word_done = (bit_cnt_q == 5'd31);
        end

        // Health failure wins over both word completion and disable.
        if (rct_trip) begin
          state_d = ST_FAULT;
          fail_d  = 1'b1;
        end else begin
          if (word_done) begin
            word_pend_d = 1'b1;
            word_d      = {acc_q, acc_bit};
          end
          if (!es_enable) state_d = ST_IDLE;
        end
      end

      ST_FAULT: begin
        if (es_health_clr) begin
          state_d    = ST_IDLE;
          fail_d     = 1'b0;
          run_d      = '0;
          last_bit_d = 1'b0;
          acc_d      = '0;
          bit_cnt_d  = '0;
`ifdef SCARV_COP_ES_VONNEUMANN_EN
          vn_phase_d = 1'b0;
`endif
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FIFO: extra pointer MSB distinguishes full from empty.
  // --------------------------------------------------------------------------
  assign fill = wr_ptr_q - rd_ptr_q;
  assign full = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign es_if.es_valid = (fill != '0) && (state_q != ST_FAULT);
  assign es_if.es_data  = (fill != '0) ? mem_q[rd_ptr_q[AW-1:0]] : 32'h0;
  assign es_fill        = fill;
  assign es_health_fail = fail_q;

  assign pop  = es_if.es_valid && es_if.es_ready;
  // A full FIFO accepts the word only when the head leaves in the same cycle.
  assign push = word_pend_q && (state_q != ST_FAULT) && (!full || pop);

  always_comb begin
    if (state_q == ST_FAULT) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge g_clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= word_q;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      bit_cnt_q   <= '0;
      run_q       <= '0;
      last_bit_q  <= 1'b0;
      fail_q      <= 1'b0;
      word_pend_q <= 1'b0;
      word_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
`ifdef SCARV_COP_ES_VONNEUMANN_EN
      vn_phase_q  <= 1'b0;
      vn_first_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      bit_cnt_q   <= bit_cnt_d;
      run_q       <= run_d;
      last_bit_q  <= last_bit_d;
      fail_q      <= fail_d;
      word_pend_q <= word_pend_d;
      word_q      <= word_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
`ifdef SCARV_COP_ES_VONNEUMANN_EN
      vn_phase_q  <= vn_phase_d;
      vn_first_q  <= vn_first_d;
`endif
    end
  end

endmodule

// File: tb/tb_scarv_cop_entropy_src.sv
// ---------------------------------------------------------------------------
// tb_scarv_cop_entropy_src
//   Directed bench for scarv_cop_entropy_src with a queue-based reference
//   model compared on every falling clock edge, plus literal expectations.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_scarv_cop_entropy_src;

  localparam int FIFO_DEPTH = 4;
  localparam int RCT_CUTOFF = 16;

  logic       g_clk = 1'b0;
  logic       g_resetn;
  logic       es_enable, noise_valid, noise_bit, es_health_clr;
  logic       es_health_fail;
  logic [2:0] es_fill;

  scarv_cop_entropy_src_if es_if ();

  scarv_cop_entropy_src #(.FIFO_DEPTH(FIFO_DEPTH), .RCT_CUTOFF(RCT_CUTOFF)) dut (
    .g_clk          (g_clk),
    .g_resetn       (g_resetn),
    .es_enable      (es_enable),
    .noise_valid    (noise_valid),
    .noise_bit      (noise_bit),
    .es_health_clr  (es_health_clr),
    .es_health_fail (es_health_fail),
    .es_fill        (es_fill),
    .es_if          (es_if)
  );

  always #5 g_clk = ~g_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model: mode, a bit count + word shift, a word queue and a
  // one-cycle "pending word" stage ahead of the queue.
  // -------------------------------------------------------------------------
  localparam int M_IDLE = 0, M_COLLECT = 1, M_FAULT = 2;
  int          m_mode;
  int          m_nbits;
  int          m_run;
  bit          m_last, m_fail, m_pend, m_vn_have, m_vn_first;
  bit [31:0]   m_word, m_pend_word;
  bit [31:0]   m_q[$];

  task automatic model_reset();
    m_mode = M_IDLE; m_nbits = 0; m_run = 0; m_last = 0; m_fail = 0;
    m_pend = 0; m_word = 0; m_pend_word = 0; m_vn_have = 0; m_vn_first = 0;
    m_q.delete();
  endtask

  task automatic model_step();
    bit pop, got, bv, trip, done;
    got = 0; bv = 0; trip = 0; done = 0;
    pop = (m_q.size() != 0) && (m_mode != M_FAULT) && es_if.es_ready;
    if (m_mode == M_FAULT) begin
      m_q.delete();
      m_pend = 0;
      if (es_health_clr) begin
        m_mode = M_IDLE; m_fail = 0; m_run = 0; m_last = 0;
        m_nbits = 0; m_word = 0; m_vn_have = 0;
      end
    end else begin
      if (pop) void'(m_q.pop_front());
      if (m_pend && m_q.size() < FIFO_DEPTH) m_q.push_back(m_pend_word);
      m_pend = 0;
      if (m_mode == M_IDLE) begin
        m_vn_have = 0;
        if (es_enable) begin m_mode = M_COLLECT; m_nbits = 0; m_word = 0; end
      end else begin
        if (noise_valid) begin
          m_run  = (noise_bit == m_last) ? ((m_run < 255) ? m_run + 1 : 255) : 1;
          m_last = noise_bit;
          trip   = (m_run == RCT_CUTOFF);
`ifdef SCARV_COP_ES_VONNEUMANN_EN
          if (!m_vn_have) begin m_vn_have = 1; m_vn_first = noise_bit; end
          else begin
            m_vn_have = 0;
            if (m_vn_first != noise_bit) begin got = 1; bv = m_vn_first; end
          end
`else
          got = 1; bv = noise_bit;
`endif
        end
        if (got) begin
          m_word = {m_word[30:0], bv};
          m_nbits++;
          if (m_nbits == 32) begin done = 1; m_nbits = 0; end
        end
        if (trip) begin
          m_mode = M_FAULT; m_fail = 1;
        end else begin
          if (done) begin m_pend = 1; m_pend_word = m_word; end
          if (!es_enable) m_mode = M_IDLE;
        end
      end
    end
  endtask

  always @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) model_reset();
    else           model_step();
  end

  // Compare process: outputs checked against the model every falling edge.
  always @(negedge g_clk) begin
    check("model_valid", 32'(es_if.es_valid), 32'((m_q.size() != 0) && (m_mode != M_FAULT)));
    check("model_data",  es_if.es_data, (m_q.size() != 0) ? m_q[0] : 32'h0);
    check("model_fill",  32'(es_fill), 32'(m_q.size()));
    check("model_fail",  32'(es_health_fail), 32'(m_fail));
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1ns after the rising edge.
  // -------------------------------------------------------------------------
  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      noise_valid = 1'b1;
      noise_bit   = w[i];
      tick();
    end
    noise_valid = 1'b0;
    noise_bit   = 1'b0;
  endtask

  task automatic pop_one();
    es_if.es_ready = 1'b1;
    tick();
    es_if.es_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_words [4];
    g_resetn = 1'b0; es_enable = 1'b0; noise_valid = 1'b0; noise_bit = 1'b0;
    es_health_clr = 1'b0; es_if.es_ready = 1'b0;
    tick(); tick();
    check("rst_valid", 32'(es_if.es_valid), 32'd0);
    check("rst_data",  es_if.es_data, 32'h0);
    check("rst_fill",  32'(es_fill), 32'd0);
    check("rst_fail",  32'(es_health_fail), 32'd0);
    g_resetn = 1'b1;
    tick();

    es_enable = 1'b1;
    tick();                                   // IDLE -> COLLECT

`ifdef SCARV_COP_ES_VONNEUMANN_EN
    // Raw 01,10,00,11 repeated 16 times -> debiased 0,1 x16.
    for (int r = 0; r < 16; r++) send_bits(32'h63, 8);
    check("vn_no_bypass", 32'(es_if.es_valid), 32'd0);
    tick();
    check("vn_valid", 32'(es_if.es_valid), 32'd1);
    check("vn_data",  es_if.es_data, 32'h5555_5555);
    check("vn_fill",  32'(es_fill), 32'd1);
    #2 g_resetn = 1'b0;
    #1;
    check("vn_async_rst_fill", 32'(es_fill), 32'd0);
    tick();
    g_resetn = 1'b1;
    tick();
`else
    // 1: single alternating word, one cycle of FIFO-write latency.
    send_bits(32'hAAAA_AAAA, 32);
    check("t1_no_bypass", 32'(es_if.es_valid), 32'd0);
    tick();
    check("t1_valid", 32'(es_if.es_valid), 32'd1);
    check("t1_data",  es_if.es_data, 32'hAAAA_AAAA);
    check("t1_fill",  32'(es_fill), 32'd1);
    pop_one();
    check("t1_popped", 32'(es_if.es_valid), 32'd0);

    // 2: five words into a four-deep FIFO, fifth dropped.
    for (int k = 0; k < 5; k++) send_bits((k % 2 == 0) ? 32'hAAAA_AAAA : 32'h5555_5555, 32);
    tick();
    check("t2_fill_full", 32'(es_fill), 32'd4);
    check("t2_head",      es_if.es_data, 32'hAAAA_AAAA);

    // 5: full FIFO, consumer ready on the word-complete cycle.
    for (int i = 31; i >= 0; i--) begin
      logic [31:0] w;
      w = 32'h1234_5678;
      noise_valid = 1'b1; noise_bit = w[i];
      es_if.es_ready = (i == 0);
      tick();
    end
    noise_valid = 1'b0; es_if.es_ready = 1'b0;
    tick();
    check("t5_fill_stays", 32'(es_fill), 32'd4);
    exp_words[0] = 32'h5555_5555; exp_words[1] = 32'hAAAA_AAAA;
    exp_words[2] = 32'h5555_5555; exp_words[3] = 32'h1234_5678;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t5_order%0d", k), es_if.es_data, exp_words[k]);
      pop_one();
    end
    check("t5_empty", 32'(es_fill), 32'd0);

    // 4: partial word discarded by a one-cycle disable.
    send_bits(32'h000A_AAAA, 20);
    es_enable = 1'b0; tick();                 // COLLECT -> IDLE
    es_enable = 1'b1; tick();                 // IDLE -> COLLECT
    send_bits(32'h1234_5678, 32);
    tick();
    check("t4_fill", 32'(es_fill), 32'd1);
    check("t4_data", es_if.es_data, 32'h1234_5678);
    pop_one();

    // 3: repetition-count failure, flush, ignore, clear, resume.
    send_bits(32'hAAAA_AAAA, 32);
    tick();
    send_bits(32'h0000_FFFF, 16);
    check("t3_fail",       32'(es_health_fail), 32'd1);
    check("t3_valid_low",  32'(es_if.es_valid), 32'd0);
    tick();
    check("t3_flushed",    32'(es_fill), 32'd0);
    send_bits(32'h0000_00F0, 8);
    check("t3_ignored",    32'(es_fill), 32'd0);
    check("t3_sticky",     32'(es_health_fail), 32'd1);
    es_health_clr = 1'b1; tick(); es_health_clr = 1'b0;
    check("t3_cleared",    32'(es_health_fail), 32'd0);
    tick();                                   // IDLE -> COLLECT
    send_bits(32'h5555_5555, 32);
    tick();
    check("t3_resumed",    es_if.es_data, 32'h5555_5555);
    pop_one();

    // 6: asynchronous reset mid-word with two words buffered.
    send_bits(32'hAAAA_AAAA, 32);
    send_bits(32'h5555_5555, 32);
    send_bits(32'h0000_0155, 10);
    check("t6_fill_two", 32'(es_fill), 32'd2);
    #2 g_resetn = 1'b0;
    #1;
    check("t6_async_valid", 32'(es_if.es_valid), 32'd0);
    check("t6_async_fill",  32'(es_fill), 32'd0);
    tick();
    g_resetn = 1'b1;
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scarv_cop_entropy_src.md
Name: scarv_cop_entropy_src

Overview:
Entropy source front-end for the coprocessor RNG. It collects raw bits from an external noise source and packs them into 32-bit words. A repetition-count health test runs on the raw bits, and healthy words are buffered in a small FIFO. Words are offered to the RNG seeding path over a valid/ready producer interface, which is the supply side of the rseed consumer.

Parameters:
FIFO_DEPTH, 4, number of 32-bit word entries; must be a power of two, minimum 2.
RCT_CUTOFF, 16, count of consecutive identical raw bits that triggers a health failure; range 2..255.

Ports:
g_clk  input  1  global clock
g_resetn  input  1  reset, asynchronous, active-low
es_enable  input  1  level; high = collect entropy
noise_valid  input  1  noise_bit is valid this cycle
noise_bit  input  1  raw noise bit
es_valid  output  1  es_data holds a word
es_ready  input  1  consumer accepts word
es_data  output  32  FIFO head word
es_health_fail  output  1  sticky health-test failure flag
es_health_clr  input  1  single-cycle pulse; clears the failure and leaves FAULT
es_fill  output  clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE.
  - es_valid=0, es_data=0, es_health_fail=0, es_fill=0.
  - Accumulator, bit counter, run counter, last_bit and FIFO pointers are all 0.
- FSM states: IDLE, COLLECT, FAULT.
  - IDLE -> COLLECT when es_enable=1. Bit counter and accumulator are cleared on entry.
  - COLLECT -> IDLE when es_enable=0. Any partial word is discarded; FIFO contents are kept and remain poppable.
  - COLLECT -> FAULT when the run counter reaches RCT_CUTOFF. This takes priority over word completion in the same cycle.
  - FAULT -> IDLE on es_health_clr=1. The clear also zeroes the run counter, last_bit, accumulator and bit counter.
  - es_health_clr has no effect outside FAULT.
- Collection, COLLECT state only:
  - Each cycle with noise_valid=1: acc <= {acc[30:0], noise_bit}; bit_cnt <= bit_cnt+1 (5-bit, wraps).
  - Word complete when noise_valid=1 and bit_cnt==31. The pushed word is {acc[30:0], noise_bit}, i.e. first bit received = MSB.
  - noise_valid is ignored in IDLE and FAULT.
- Health test (repetition count), raw bits, COLLECT only:
  - If noise_bit==last_bit: run++, saturating at 255. Otherwise run=1.
  - last_bit <= noise_bit.
  - The first bit after reset or clear starts run=1.
- FAULT entry:
  - es_health_fail <= 1 (sticky until es_health_clr).
  - FIFO flushed next cycle: pointers zeroed, es_fill=0.
  - The word in progress is discarded.
- FIFO:
  - Push on word complete if not full, or if full and a pop occurs in the same cycle.
  - When full with no pop, the completed word is dropped silently and collection continues.
  - es_valid = (es_fill!=0) && state!=FAULT.
  - es_data = head entry; 0 when empty.
  - Pop when es_valid && es_ready.
  - Latency: final bit of a word sampled at edge N gives es_valid=1 after edge N+1 if the FIFO was empty. There is no bypass path.
  - Pointers are log2(FIFO_DEPTH)+1 bits, wrap naturally; full = MSBs differ and the other bits are equal.
- Simultaneous events:
  - Push and pop on the same cycle with the FIFO empty: not possible, since es_valid=0.
  - es_enable falling on a word-complete cycle: the word is pushed, then the FSM goes to IDLE.
- Reset mid-operation: all state discarded immediately, FIFO empty.

Optional Feature:
SCARV_COP_ES_VONNEUMANN_EN
- Defined: von Neumann debiaser between the health test and the accumulator.
  - Raw bits are paired as (first, second): 01 -> 0, 10 -> 1, 00/11 -> discarded.
  - Only debiased bits shift into the accumulator and advance bit_cnt.
  - The health test still sees every raw bit.
  - The pair phase resets on reset, IDLE entry and FAULT clear.
- Undefined: every raw valid bit is accumulated directly; no pair register is present.

Test Plan:
1. Enable; feed 32 valid bits alternating 1,0 starting with 1 -> es_valid=1 one cycle after the last bit, es_data=32'hAAAAAAAA, es_fill=1; pop with es_ready=1 -> es_valid=0.
2. es_ready=0, FIFO_DEPTH=4; feed 5 words of alternating pattern 1,0 then 0,1 (32'hAAAAAAAA / 32'h55555555) -> es_fill=4, 5th word dropped; pops return the first 4 words in order.
3. Feed 16 consecutive 1s with default RCT_CUTOFF=16 -> es_health_fail=1 at the 16th bit, es_valid=0, es_fill=0 next cycle; further noise ignored; pulse es_health_clr -> fail=0, state IDLE, then COLLECT because es_enable=1.
4. Feed 20 bits, then drop es_enable for 1 cycle, then feed 32 bits of pattern 32'h12345678 -> the single word output is 32'h12345678.
5. FIFO full with es_ready=1 on the word-complete cycle -> head popped, new word pushed, es_fill stays 4.
6. Assert g_resetn=0 asynchronously mid-word with es_fill=2 -> es_valid=0 and es_fill=0 immediately, without a clock edge. With SCARV_COP_ES_VONNEUMANN_EN, raw stream 01,10,00,11 repeated -> debiased 0,1 per repeat; 64 pairs yield 32'h55555555.
